fact_engine: RTL and testbench

//   Iterative factorial unit for the GPIO/FACT subsystem. Consumes the 4-bit operand

---
 rtl/fact_engine.sv | 65 ++++++
 tb/tb_fact_engine.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/fact_engine.sv
// fact_engine: iterative N! unit with GO/DONE handshake, one multiply per cycle, overflow flag for N > MAX_N
module fact_engine #(
  parameter int N_WIDTH = 4,
  parameter int P_WIDTH = 32,
  parameter int MAX_N   = 12
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               GO,
  input  logic [N_WIDTH-1:0] N,
  output logic               BUSY,
  output logic               DONE,
  output logic               ERR,
  output logic [P_WIDTH-1:0] PRODUCT
);
  typedef enum logic [1:0] {S_IDLE, S_MULT, S_DONE} state_t;
  localparam logic [N_WIDTH-1:0] MAXN = N_WIDTH'(MAX_N);
  localparam logic [N_WIDTH-1:0] ONE = N_WIDTH'(1);
  state_t state, state_d;
  logic [N_WIDTH-1:0] cnt, cnt_d;
  logic [P_WIDTH-1:0] acc, acc_d, prod_d;
  logic err, err_d;
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state   <= S_IDLE;
      cnt     <= '0;
      acc     <= '0;
      PRODUCT <= '0;
      err     <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      acc     <= acc_d;
      PRODUCT <= prod_d;
      err     <= err_d;
    end
  end
  // GO is only honoured outside MULT; a capture from DONE behaves exactly like one from IDLE
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    acc_d   = acc;
    prod_d  = PRODUCT;
    err_d   = err;
    if (state == S_MULT) begin
      if (cnt > ONE) begin
        acc_d = acc * P_WIDTH'(cnt);
        cnt_d = cnt - ONE;
      end else begin
        prod_d  = acc;
        err_d   = 1'b0;
        state_d = S_DONE;
      end
    end else if (GO) begin
      cnt_d   = N;
      acc_d   = P_WIDTH'(1);
      state_d = (N > MAXN) ? S_DONE : S_MULT;
      err_d   = (N > MAXN) ? 1'b1 : err;
      prod_d  = (N > MAXN) ? '0 : PRODUCT;
    end
  end
  assign BUSY = (state == S_MULT);
  assign DONE = (state == S_DONE);
  assign ERR  = DONE & err;
endmodule

// File: tb/tb_fact_engine.sv
// tb_fact_engine: directed stimulus, cycle-level behavioural model plus literal latency/result checks
module tb_fact_engine;
  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic GO = 1'b0;
  logic [3:0] N = '0;
  logic BUSY, DONE, ERR;
  logic [31:0] PRODUCT;
  int n_chk = 0;
  int n_fail = 0;
  bit check_en = 0;

  fact_engine dut (
    .CLK(CLK), .RST(RST), .GO(GO), .N(N),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .PRODUCT(PRODUCT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    end
  endtask

  function automatic logic [31:0] fact(input int n);
    longint p = 1;
    for (int i = 2; i <= n; i++) p = p * i;
    return p[31:0];
  endfunction

  // model: remaining busy cycles, the result pending for DONE, and what DONE shows
  int m_left;
  logic m_done, m_err;
  logic [31:0] m_prod, m_pend;
  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      m_left = 0; m_done = 0; m_err = 0; m_prod = 0; m_pend = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_done = 1; m_err = 0; m_prod = m_pend;
      end
    end else if (GO) begin
      if (N > 12) begin
        m_done = 1; m_err = 1; m_prod = 0;
      end else begin
        m_done = 0;
        m_left = (N < 2) ? 1 : int'(N);
        m_pend = fact(int'(N));
      end
    end
  end

  always @(negedge CLK) if (check_en) begin
    chk("model_busy", {31'b0, BUSY}, {31'b0, m_left > 0});
    chk("model_done", {31'b0, DONE}, {31'b0, m_done});
    chk("model_err", {31'b0, ERR}, {31'b0, m_done & m_err});
    chk("model_product", PRODUCT, m_prod);
  end

  task automatic run(input int n, input int exp_lat, input logic [31:0] exp_p, input logic exp_e, input string nm);
    int lat = 0;
    logic sb = 0;
    @(negedge CLK);
    GO = 1; N = 4'(n);
    do begin
      @(posedge CLK);
      lat++;
      @(negedge CLK);
      GO = 0;
      sb |= BUSY;
    end while (!DONE && lat < 40);
    chk({nm, "_latency"}, lat, exp_lat);
    chk({nm, "_product"}, PRODUCT, exp_p);
    chk({nm, "_err"}, {31'b0, ERR}, {31'b0, exp_e});
    if (exp_e) chk({nm, "_busy_seen"}, {31'b0, sb}, 32'd0);
  endtask

  task automatic wait_done(input string nm);
    int k = 0;
    while (!DONE && k < 40) begin
      @(negedge CLK);
      k++;
    end
    chk({nm, "_done_timeout"}, {31'b0, DONE}, 32'd1);
  endtask

  initial begin
    #1;
    chk("reset_busy", {31'b0, BUSY}, 32'd0);
    chk("reset_done", {31'b0, DONE}, 32'd0);
    chk("reset_err", {31'b0, ERR}, 32'd0);
    chk("reset_product", PRODUCT, 32'd0);
    repeat (2) @(negedge CLK);
    RST = 1;
    check_en = 1;
    run(5, 6, 32'd120, 0, "n5");
    run(0, 2, 32'd1, 0, "n0");
    run(1, 2, 32'd1, 0, "n1");
    run(12, 13, 32'h1C8CFC00, 0, "n12");
    run(13, 1, 32'd0, 1, "n13");
    run(15, 1, 32'd0, 1, "n15");
    run(4, 5, 32'd24, 0, "n4_after_err");
    @(negedge CLK);
    GO = 1; N = 4'd7;
    @(negedge CLK);
    GO = 0;
    @(negedge CLK);
    @(negedge CLK);
    GO = 1; N = 4'd2;
    @(negedge CLK);
    GO = 0;
    wait_done("n7");
    chk("n7_product", PRODUCT, 32'd5040);
    @(negedge CLK);
    GO = 1; N = 4'd9;
    @(negedge CLK);
    GO = 0;
    repeat (3) @(negedge CLK);
    #2 RST = 0;
    #1;
    chk("async_busy", {31'b0, BUSY}, 32'd0);
    chk("async_done", {31'b0, DONE}, 32'd0);
    chk("async_err", {31'b0, ERR}, 32'd0);
    chk("async_product", PRODUCT, 32'd0);
    @(negedge CLK);
    RST = 1;
    run(3, 4, 32'd6, 0, "n3");
    @(negedge CLK);
    GO = 1; N = 4'd2;
    repeat (10) @(negedge CLK);
    GO = 0;
    wait_done("held_go");
    chk("held_go_product", PRODUCT, 32'd2);
    repeat (3) @(negedge CLK);
    check_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
